// File: rtl/ntt_coeff_loader.sv
// -----------------------------------------------------------------------------
// ntt_coeff_loader
//
// Upstream feeder for the NTT/INTT processing unit (PU). It accepts one N-bit
// coefficient per cycle on a valid/ready stream. Each coefficient is reduced
// mod Q with a single conditional subtract. D coefficients are gathered into a
// fill buffer. A completed frame is then copied into the committed output
// register `a`, together with its mode flag, and a one-cycle pu_start pulse is
// raised. The committed vector holds for HOLD cycles (busy) while the PU works.
// The fill buffer and the committed register together form the double buffer,
// so the next frame can be filled while the current one is held.
//
// Ports
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous, active-low reset
//   in_valid  in   1     input coefficient valid
//   in_ready  out  1     loader can accept (low only while a full frame waits)
//   in_coeff  in   N     unsigned coefficient, 0..2^N-1
//   in_inv    in   1     frame mode (0 NTT, 1 INTT), sampled with coefficient 0
//   in_last   in   1     marks coefficient D-1 of the frame
//   a         out  D*N   committed vector, slot s at a[N*(s+1)-1:N*s]
//   inv       out  1     mode of the committed vector
//   pu_start  out  1     one-cycle pulse: a/inv just committed
//   busy      out  1     committed vector is inside its HOLD window
//   frame_err out  1     one-cycle pulse on an in_last framing violation
// -----------------------------------------------------------------------------
module ntt_coeff_loader #(
    parameter int N      = 17,
    parameter int D      = 16,
    parameter int Q      = 65537,
    parameter int HOLD   = 16,
    parameter int BITREV = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_coeff,
    input  logic             in_inv,
    input  logic             in_last,
    output logic [D*N-1:0]   a,
    output logic             inv,
    output logic             pu_start,
    output logic             busy,
    output logic             frame_err
);

    localparam int LOGD = (D > 1) ? $clog2(D) : 1;
    localparam int HW   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [N:0]      Q_EXT    = (N + 1)'(Q);
    localparam logic [HW-1:0]   HOLD_LD  = HW'(HOLD);
    localparam logic [LOGD-1:0] LAST_IDX = LOGD'(D - 1);

    // Slot a coefficient index lands in: identity, or bit-reversed index.
    function automatic logic [LOGD-1:0] slot_of(input logic [LOGD-1:0] c);
        logic [LOGD-1:0] r;
        r = c;
        if (BITREV != 0) begin
            for (int i = 0; i < LOGD; i++) begin
                r[i] = c[LOGD-1-i];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------ state
    logic [LOGD-1:0] count_q,      count_d;
    logic            frame_full_q, frame_full_d;
    logic            frame_inv_q,  frame_inv_d;
    logic [HW-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [D*N-1:0]  a_q,          a_d;
    logic            inv_q,        inv_d;
    logic            pu_start_q,   pu_start_d;
    logic            frame_err_q,  frame_err_d;
    logic [N-1:0]    fill_q [D];
    logic [N-1:0]    fill_d [D];

    // --------------------------------------------------------- datapath nets
    logic            xfer;
    logic            commit;
    logic [N:0]      coeff_ext;
    logic [N:0]      coeff_sub;
    logic [N-1:0]    coeff_red;
    logic [LOGD-1:0] wr_slot;

    assign in_ready  = !frame_full_q;
    assign xfer      = in_valid && in_ready;
    // in_ready is low whenever frame_full is set, so a commit and a transfer
    // can never happen on the same edge.
    assign commit    = frame_full_q && (hold_cnt_q == '0);

    // Input is below 2^N <= 2Q, so one conditional subtract brings it below Q.
    assign coeff_ext = {1'b0, in_coeff};
    assign coeff_sub = coeff_ext - Q_EXT;
    assign coeff_red = (coeff_ext >= Q_EXT) ? coeff_sub[N-1:0] : in_coeff;
    assign wr_slot   = slot_of(count_q);

    // -------------------------------------------------------- next-state logic
    // NOTE: every variable gets its default before any condition; a path that
    // left one unassigned would make synthesis infer a latch.
    always_comb begin
        count_d      = count_q;
        frame_full_d = frame_full_q;
        frame_inv_d  = frame_inv_q;
        frame_err_d  = 1'b0;
        fill_d       = fill_q;
        hold_cnt_d   = hold_cnt_q;
        a_d          = a_q;
        inv_d        = inv_q;
        pu_start_d   = 1'b0;

        // Fill side.
        if (xfer) begin
            fill_d[wr_slot] = coeff_red;
            if (count_q == '0) begin
                frame_inv_d = in_inv;
            end
            if (count_q == LAST_IDX) begin
                // Frame is complete even without in_last; that case only
                // raises the error pulse.
                frame_full_d = 1'b1;
                count_d      = '0;
                frame_err_d  = !in_last;
            end else if (in_last) begin
                // Early in_last: drop the partial frame. The slots already
                // written are overwritten by the next frame before any commit.
                frame_err_d = 1'b1;
                count_d     = '0;
            end else begin
                count_d = count_q + LOGD'(1);
            end
        end

        // Commit side.
        if (commit) begin
            for (int s = 0; s < D; s++) begin
                a_d[N*s +: N] = fill_q[s];
            end
            inv_d        = frame_inv_q;
            pu_start_d   = 1'b1;
            hold_cnt_d   = HOLD_LD;
            frame_full_d = 1'b0;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            frame_full_q <= 1'b0;
            frame_inv_q  <= 1'b0;
            hold_cnt_q   <= '0;
            a_q          <= '0;
            inv_q        <= 1'b0;
            pu_start_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            frame_full_q <= frame_full_d;
            frame_inv_q  <= frame_inv_d;
            hold_cnt_q   <= hold_cnt_d;
            a_q          <= a_d;
            inv_q        <= inv_d;
            pu_start_q   <= pu_start_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // NOTE: the fill buffer is a plain storage array with no reset; a commit
    // only follows D consecutive writes that cover every slot, so stale
    // contents are never observed and the array can map onto RAM-style cells.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    // --------------------------------------------------------------- outputs
    assign a         = a_q;
    assign inv       = inv_q;
    assign pu_start  = pu_start_q;
    assign busy      = (hold_cnt_q != '0);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_ntt_coeff_loader
//
// Three loader instances share clock and reset:
//   unit 0: defaults (HOLD=16, BITREV=0)
//   unit 1: BITREV=1
//   unit 2: HOLD=20
// Directed sequences cover reset, reduction, bit-reversal, back-to-back hold,
// framing errors and reset mid-frame. A randomized stream on unit 0 is then
// compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_ntt_coeff_loader;

    localparam int N  = 17;
    localparam int D  = 16;
    localparam int Q  = 65537;
    localparam int NU = 3;
    localparam int W  = N * D;

    typedef logic [W-1:0] vec_t;
    typedef struct {
        logic [N-1:0] coeff;
        logic [N-1:0] stored;
    } red_vec_t;
    typedef struct {
        vec_t v;
        logic inv;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid  [NU];
    logic         in_ready  [NU];
    logic [N-1:0] in_coeff  [NU];
    logic         in_inv    [NU];
    logic         in_last   [NU];
    vec_t         a         [NU];
    logic         inv       [NU];
    logic         pu_start  [NU];
    logic         busy      [NU];
    logic         frame_err [NU];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pu_cnt   [NU];
    int ferr_cnt [NU];
    bit rand_on  = 1'b0;

    frame_t   exp_q[$];
    frame_t   obs_q[$];
    red_vec_t red_tbl [D];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        ntt_coeff_loader #(
            .N      (N),
            .D      (D),
            .Q      (Q),
            .HOLD   ((g == 2) ? 20 : 16),
            .BITREV ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_coeff  (in_coeff[g]),
            .in_inv    (in_inv[g]),
            .in_last   (in_last[g]),
            .a         (a[g]),
            .inv       (inv[g]),
            .pu_start  (pu_start[g]),
            .busy      (busy[g]),
            .frame_err (frame_err[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and committed-frame capture, sampled mid-cycle.
    initial begin
        for (int u = 0; u < NU; u++) begin
            pu_cnt[u]   = 0;
            ferr_cnt[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                if (pu_start[u] === 1'b1) pu_cnt[u]++;
                if (frame_err[u] === 1'b1) ferr_cnt[u]++;
            end
            if (rand_on && pu_start[0] === 1'b1) begin
                obs_q.push_back('{v: a[0], inv: inv[0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- helpers
    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the loader takes it. Returns one
    // time unit after the accepting edge with in_valid still asserted.
    task automatic send_beat(input int u, input logic [N-1:0] c,
                             input logic iv, input logic lst);
        bit took;
        took = 1'b0;
        in_valid[u] = 1'b1;
        in_coeff[u] = c;
        in_inv[u]   = iv;
        in_last[u]  = lst;
        for (int i = 0; i < 200 && !took; i++) begin
            took = in_ready[u];
            step();
        end
        check($sformatf("u%0d_beat_accepted", u), vec_t'(took), 1);
    endtask

    task automatic idle(input int u);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic wait_commit(input int u);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pu_start[u] === 1'b1) seen = 1'b1;
            else step();
        end
        check($sformatf("u%0d_commit_seen", u), vec_t'(seen), 1);
    endtask

    function automatic int bitrev4(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((k >> i) & 1) != 0) r |= (1 << (3 - i));
        end
        return r;
    endfunction

    // Frame-level reference model for the random stream (unit 0, no bitrev).
    int   m_cnt = 0;
    int   m_err = 0;
    int   m_buf [D];
    logic m_inv = 1'b0;

    task automatic model_beat(input logic [N-1:0] c, input logic iv, input logic lst);
        int   val;
        vec_t v;
        val = int'(c);
        if (val >= Q) val = val - Q;
        if (m_cnt == 0) m_inv = iv;
        m_buf[m_cnt] = val;
        if (m_cnt == D - 1) begin
            v = '0;
            for (int s = 0; s < D; s++) v[N*s +: N] = N'(m_buf[s]);
            exp_q.push_back('{v: v, inv: m_inv});
            if (!lst) m_err++;
            m_cnt = 0;
        end else if (lst) begin
            m_err++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // -------------------------------------------------------------------- test
    initial begin
        vec_t ev, f1, f2;
        int   nb, t1, t2, pu_before, fe_before;

        red_tbl[0]  = '{17'h10000, 17'h10000};
        red_tbl[1]  = '{17'h10001, 17'h00000};
        red_tbl[2]  = '{17'h1FFFF, 17'h0FFFE};
        red_tbl[3]  = '{17'h00000, 17'h00000};
        red_tbl[4]  = '{17'h00001, 17'h00001};
        red_tbl[5]  = '{17'h10002, 17'h00001};
        red_tbl[6]  = '{17'h0FFFF, 17'h0FFFF};
        red_tbl[7]  = '{17'h1FFFE, 17'h0FFFD};
        red_tbl[8]  = '{17'h18000, 17'h07FFF};
        red_tbl[9]  = '{17'h12345, 17'h02344};
        red_tbl[10] = '{17'h0ABCD, 17'h0ABCD};
        red_tbl[11] = '{17'h1ABCD, 17'h0ABCC};
        red_tbl[12] = '{17'h10003, 17'h00002};
        red_tbl[13] = '{17'h00100, 17'h00100};
        red_tbl[14] = '{17'h1FF00, 17'h0FEFF};
        red_tbl[15] = '{17'h0FFFE, 17'h0FFFE};

        for (int u = 0; u < NU; u++) begin
            in_valid[u] = 1'b0;
            in_coeff[u] = '0;
            in_inv[u]   = 1'b0;
            in_last[u]  = 1'b0;
        end

        // Reset state.
        rst = 1'b0;
        repeat (3) step();
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d_rst_a", u), a[u], 0);
            check($sformatf("u%0d_rst_inv", u), vec_t'(inv[u]), 0);
            check($sformatf("u%0d_rst_pu_start", u), vec_t'(pu_start[u]), 0);
            check($sformatf("u%0d_rst_busy", u), vec_t'(busy[u]), 0);
            check($sformatf("u%0d_rst_frame_err", u), vec_t'(frame_err[u]), 0);
        end
        rst = 1'b1;
        step();
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d_ready_after_rst", u), vec_t'(in_ready[u]), 1);
        end

        // 1: slot k = k+1, commit one cycle after last beat, busy 16 cycles.
        ev = '0;
        for (int k = 0; k < D; k++) begin
            send_beat(0, N'(k + 1), 1'b0, k == D - 1);
            ev[N*k +: N] = N'(k + 1);
        end
        idle(0);
        check("t1_pu_not_yet", vec_t'(pu_start[0]), 0);
        check("t1_ready_low_while_full", vec_t'(in_ready[0]), 0);
        step();
        check("t1_pu_start", vec_t'(pu_start[0]), 1);
        check("t1_a", a[0], ev);
        check("t1_inv", vec_t'(inv[0]), 0);
        check("t1_ready_after_commit", vec_t'(in_ready[0]), 1);
        nb = 0;
        while (busy[0] === 1'b1 && nb < 40) begin
            nb++;
            step();
        end
        check("t1_busy_cycles", vec_t'(nb), 16);
        check("t1_no_frame_err", vec_t'(ferr_cnt[0]), 0);
        check("t1_one_commit", vec_t'(pu_cnt[0]), 1);

        // 2: reduction table, inv=1 sampled on coefficient 0.
        for (int k = 0; k < D; k++) begin
            send_beat(0, red_tbl[k].coeff, k == 0, k == D - 1);
        end
        idle(0);
        wait_commit(0);
        for (int k = 0; k < D; k++) begin
            check($sformatf("t2_slot%0d", k), vec_t'(a[0][N*k +: N]), vec_t'(red_tbl[k].stored));
        end
        check("t2_inv", vec_t'(inv[0]), 1);

        // 3: BITREV=1 placement and inv capture.
        ev = '0;
        for (int k = 0; k < D; k++) begin
            send_beat(1, N'(k), k == 0, k == D - 1);
            ev[N*bitrev4(k) +: N] = N'(k);
        end
        idle(1);
        wait_commit(1);
        check("t3_slot8", vec_t'(a[1][N*8 +: N]), 1);
        check("t3_slot1", vec_t'(a[1][N*1 +: N]), 8);
        check("t3_a", a[1], ev);
        check("t3_inv", vec_t'(inv[1]), 1);

        // 4: back-to-back frames with HOLD=20.
        f1 = '0;
        f2 = '0;
        for (int k = 0; k < D; k++) begin
            f1[N*k +: N] = N'(100 + k);
            f2[N*k +: N] = N'(200 + k);
        end
        for (int k = 0; k < D; k++) send_beat(2, N'(100 + k), 1'b0, k == D - 1);
        idle(2);
        wait_commit(2);
        t1 = cyc;
        check("t4_a_frame1", a[2], f1);
        for (int k = 0; k < D; k++) begin
            send_beat(2, N'(200 + k), 1'b1, k == D - 1);
            check("t4_a_stable_fill", a[2], f1);
            check("t4_busy_fill", vec_t'(busy[2]), 1);
        end
        idle(2);
        nb = 0;
        while (pu_start[2] !== 1'b1 && nb < 40) begin
            check("t4_ready_low_wait", vec_t'(in_ready[2]), 0);
            check("t4_a_stable_wait", a[2], f1);
            nb++;
            step();
        end
        t2 = cyc;
        check("t4_commit_period", vec_t'(t2 - t1), 21);
        check("t4_a_frame2", a[2], f2);
        check("t4_inv_frame2", vec_t'(inv[2]), 1);

        // 5a: early in_last on k=5 drops the partial frame.
        repeat (20) step();
        pu_before = pu_cnt[0];
        fe_before = ferr_cnt[0];
        for (int k = 0; k < 6; k++) send_beat(0, N'(900 + k), 1'b1, k == 5);
        idle(0);
        check("t5_frame_err_pulse", vec_t'(frame_err[0]), 1);
        check("t5_ready_after_drop", vec_t'(in_ready[0]), 1);
        step();
        check("t5_frame_err_one_cycle", vec_t'(frame_err[0]), 0);
        repeat (20) step();
        check("t5_no_commit", vec_t'(pu_cnt[0] - pu_before), 0);
        check("t5_err_count", vec_t'(ferr_cnt[0] - fe_before), 1);
        ev = '0;
        for (int k = 0; k < D; k++) begin
            send_beat(0, N'(300 + k), 1'b0, k == D - 1);
            ev[N*k +: N] = N'(300 + k);
        end
        idle(0);
        wait_commit(0);
        check("t5_next_frame_a", a[0], ev);
        check("t5_next_frame_inv", vec_t'(inv[0]), 0);

        // 5b: missing in_last on coefficient D-1: error pulse, frame still commits.
        repeat (20) step();
        ev = '0;
        for (int k = 0; k < D; k++) begin
            send_beat(0, N'(17'h1FFF0 + k), 1'b0, 1'b0);
            ev[N*k +: N] = N'(17'h1FFF0 + k - Q);
        end
        idle(0);
        check("t5b_frame_err_pulse", vec_t'(frame_err[0]), 1);
        step();
        check("t5b_commit", vec_t'(pu_start[0]), 1);
        check("t5b_a", a[0], ev);

        // 6: reset on beat 7 of a frame while busy.
        repeat (20) step();
        for (int k = 0; k < D; k++) send_beat(0, N'(400 + k), 1'b1, k == D - 1);
        idle(0);
        wait_commit(0);
        step();
        for (int k = 0; k < 7; k++) send_beat(0, N'(700 + k), 1'b1, 1'b0);
        check("t6_busy_before_rst", vec_t'(busy[0]), 1);
        rst = 1'b0;
        #1;
        idle(0);
        check("t6_rst_a", a[0], 0);
        check("t6_rst_inv", vec_t'(inv[0]), 0);
        check("t6_rst_busy", vec_t'(busy[0]), 0);
        check("t6_rst_pu_start", vec_t'(pu_start[0]), 0);
        check("t6_rst_frame_err", vec_t'(frame_err[0]), 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t6_ready_after_release", vec_t'(in_ready[0]), 1);
        ev = '0;
        for (int k = 0; k < D; k++) begin
            send_beat(0, N'(500 + k), 1'b0, k == D - 1);
            ev[N*k +: N] = N'(500 + k);
        end
        idle(0);
        wait_commit(0);
        check("t6_slot0_first_beat", vec_t'(a[0][N-1:0]), 500);
        check("t6_fresh_frame_a", a[0], ev);

        // Random stream on unit 0 against the frame-level model.
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        pu_before = pu_cnt[0];
        fe_before = ferr_cnt[0];
        rand_on   = 1'b1;
        for (int f = 0; f < 10; f++) begin
            int kind, len;
            kind = int'($urandom_range(0, 3));
            len  = (kind == 2) ? int'($urandom_range(1, 15)) : D;
            for (int k = 0; k < len; k++) begin
                logic [N-1:0] c;
                logic         iv, lst;
                if ($urandom_range(0, 3) == 0) c = N'($urandom_range(Q, 131071));
                else                           c = N'($urandom_range(0, 131071));
                iv  = 1'($urandom_range(0, 1));
                lst = (kind == 2) ? (k == len - 1) : (kind != 3 && k == D - 1);
                if ($urandom_range(0, 3) == 0) begin
                    idle(0);
                    repeat ($urandom_range(1, 3)) step();
                end
                send_beat(0, c, iv, lst);
                model_beat(c, iv, lst);
            end
        end
        idle(0);
        repeat (60) step();
        rand_on = 1'b0;
        check("rand_commit_count", vec_t'(obs_q.size()), vec_t'(exp_q.size()));
        check("rand_pu_count", vec_t'(pu_cnt[0] - pu_before), vec_t'(exp_q.size()));
        check("rand_err_count", vec_t'(ferr_cnt[0] - fe_before), vec_t'(m_err));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("rand_frame%0d_a", i), obs_q[i].v, exp_q[i].v);
            check($sformatf("rand_frame%0d_inv", i), vec_t'(obs_q[i].inv), vec_t'(exp_q[i].inv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
